// File: rtl/bus_pkg.sv
// Shared definitions for the 16-bit bus arbiter slice: widths, FSM state
// type and the rotating-priority search helper.
package bus_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Returns {found, index} of the first set req bit at base, base+1, ... (mod 4).
  // Scans from the farthest offset inward so the nearest hit is written last.
  function automatic logic [2:0] rr_search(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         base);
    logic [1:0] idx;
    rr_search = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      idx = base + 2'(i - 1);
      if (req[idx]) rr_search = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/bus_arbiter_mux4way16.sv
// 4-way 16-bit mux tree built from three 2:1 muxes; used to steer the
// granted requester's word onto the shared bus.
module mux16
  import bus_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] out
);

  assign out = sel ? b : a;

endmodule

module mux4way16
  import bus_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] ab, cd;

  mux16 u_ab   (.a(a),  .b(b),  .sel(sel[0]), .out(ab));
  mux16 u_cd   (.a(c),  .b(d),  .sel(sel[0]), .out(cd));
  mux16 u_root (.a(ab), .b(cd), .sel(sel[1]), .out(out));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit valid/ready bus among four
// requesters, with a per-grant burst cap and same-cycle re-arbitration.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  last,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [3:0]  grant,
  output logic [1:0]  grant_id
);

  state_t      state, state_nx;
  logic [3:0]  grant_nx;
  logic [1:0]  gid_nx;
  logic [1:0]  ptr, ptr_nx;
  logic [3:0]  beat_cnt, cnt_nx;
  logic [1:0]  search_base;
  logic        win_found;
  logic [1:0]  win_idx;
  logic        accept;
  logic        rel;
  logic [15:0] mux_out;

  mux4way16 u_mux (
    .a   (data0),
    .b   (data1),
    .c   (data2),
    .d   (data3),
    .sel (grant_id),
    .out (mux_out)
  );

  // While busy, the search base is the post-release pointer so a releasing
  // requester can be re-granted only when nobody else is asking.
  assign search_base          = (state == BUSY) ? grant_id + 2'd1 : ptr;
  assign {win_found, win_idx} = rr_search(req, search_base);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      grant_id <= gid_nx;
      ptr      <= ptr_nx;
      beat_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    gid_nx    = grant_id;
    ptr_nx    = ptr;
    cnt_nx    = beat_cnt;
    out_valid = 1'b0;
    accept    = 1'b0;
    rel       = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          grant_nx = 4'b0001 << win_idx;
          gid_nx   = win_idx;
          cnt_nx   = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        out_valid = req[grant_id];
        accept    = out_valid & out_ready;
        rel       = ~req[grant_id] |
                    (accept & (last[grant_id] | (beat_cnt == 4'(BURST_MAX - 1))));
        if (rel) begin
          ptr_nx = grant_id + 2'd1;
          if (win_found) begin
            grant_nx = 4'b0001 << win_idx;
            gid_nx   = win_idx;
            cnt_nx   = '0;
          end else begin
            grant_nx = '0;
            state_nx = IDLE;
          end
        end else if (accept) begin
          cnt_nx = beat_cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_data = out_valid ? mux_out : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed + randomized bench for bus_arbiter against a queue-free
// behavioural model of the round-robin / burst-cap rules.
module tb_bus_arbiter;

  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  last = '0;
  logic [15:0] data0 = '0, data1 = '0, data2 = '0, data3 = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  grant;
  logic [1:0]  grant_id;

  bus_arbiter #(.BURST_MAX(BM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: owner = -1 when nobody holds the bus.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_gid   = 0;

  int seq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word(input int i);
    case (i)
      0: return data0;
      1: return data1;
      2: return data2;
      default: return data3;
    endcase
  endfunction

  function automatic int winner(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++)
      if (r[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  function automatic bit m_valid();
    return (m_owner >= 0) && req[m_owner];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_gid = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  eg;
    ev = m_valid();
    ed = ev ? word(m_owner) : 16'h0000;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".data"},  32'(out_data),  32'(ed));
    chk({tag, ".grant"}, 32'(grant),     32'(eg));
    chk({tag, ".gid"},   32'(grant_id),  32'(m_gid));
  endtask

  // Apply one clock edge to DUT and model using the inputs currently driven.
  task automatic advance();
    bit v, acc, rl;
    int w;
    v   = m_valid();
    acc = v && out_ready;
    if (m_owner < 0) begin
      w = winner(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_gid = w; m_cnt = 0; end
    end else begin
      rl = !req[m_owner] || (acc && (last[m_owner] || (m_cnt + 1 == BM)));
      if (rl) begin
        m_ptr = (m_owner + 1) % 4;
        w = winner(req, m_ptr);
        if (w >= 0) begin m_owner = w; m_gid = w; m_cnt = 0; end
        else m_owner = -1;
      end else if (acc) begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rdy, input string tag);
    req = r; last = l; out_ready = rdy;
    #1;
    check_outputs(tag);
    advance();
  endtask

  task automatic do_reset();
    req = '0; last = '0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst.valid", 32'(out_valid), 32'(0));
    chk("rst.grant", 32'(grant), 32'(0));
    chk("rst.data",  32'(out_data), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    data0 = 16'h1111; data1 = 16'hBEEF; data2 = 16'h2222; data3 = 16'h3333;
    #12;
    check_outputs("reset");
    chk("reset.gid", 32'(grant_id), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, two-beat burst
    cyc(4'b0010, 4'b0000, 1'b1, "single.req");
    chk("single.grant", 32'(grant), 32'(4'b0010));
    cyc(4'b0010, 4'b0000, 1'b1, "single.b1");
    chk("single.b2data", 32'(out_data), 32'(16'hBEEF));
    cyc(4'b0010, 4'b0010, 1'b1, "single.b2");
    cyc(4'b0000, 4'b0000, 1'b1, "single.idle");
    chk("single.idlegrant", 32'(grant), 32'(0));

    // Round-robin fairness
    do_reset();
    seq.delete();
    cyc(4'b1111, 4'b1111, 1'b1, "rr.req");
    for (int i = 0; i < 5; i++) begin
      seq.push_back(int'(grant_id));
      chk("rr.valid", 32'(out_valid), 32'(1));
      cyc(4'b1111, 4'b1111, 1'b1, "rr");
    end
    for (int i = 0; i < 5; i++) chk("rr.order", 32'(seq[i]), 32'(i % 4));

    // Burst cap
    do_reset();
    seq.delete();
    cyc(4'b0101, 4'b0000, 1'b1, "cap.req");
    for (int i = 0; i < 12; i++) begin
      seq.push_back(int'(grant_id));
      cyc(4'b0101, 4'b0000, 1'b1, "cap");
    end
    for (int i = 0; i < 12; i++) chk("cap.order", 32'(seq[i]), 32'(((i / BM) % 2) * 2));

    // Backpressure
    do_reset();
    cyc(4'b0001, 4'b0000, 1'b1, "bp.req");
    cyc(4'b0001, 4'b0000, 1'b1, "bp.b1");
    for (int i = 0; i < 3; i++) begin
      req = 4'b0001; out_ready = 1'b0; #1;
      chk("bp.valid", 32'(out_valid), 32'(1));
      chk("bp.grant", 32'(grant), 32'(4'b0001));
      cyc(4'b0001, 4'b0000, 1'b0, "bp.stall");
    end
    for (int i = 0; i < 4; i++) cyc(4'b0001, 4'b0000, 1'b1, "bp.resume");

    // Abort with req[3] pending
    do_reset();
    cyc(4'b0001, 4'b0000, 1'b1, "ab.req");
    cyc(4'b1001, 4'b0000, 1'b1, "ab.b1");
    req = 4'b1000; #1;
    chk("ab.valid", 32'(out_valid), 32'(0));
    cyc(4'b1000, 4'b0000, 1'b1, "ab.drop");
    chk("ab.grant", 32'(grant), 32'(4'b1000));

    // Reset during beat 2
    do_reset();
    cyc(4'b0001, 4'b0000, 1'b1, "mr.req");
    cyc(4'b0001, 4'b0000, 1'b1, "mr.b1");
    req = 4'b0001; #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mr.valid", 32'(out_valid), 32'(0));
    chk("mr.grant", 32'(grant), 32'(0));
    chk("mr.data",  32'(out_data), 32'(0));
    req = 4'b1000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1000, 4'b0000, 1'b1, "mr.after");
    chk("mr.grant3", 32'(grant), 32'(4'b1000));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (req | 4'($urandom & $urandom));
      data0 = 16'($urandom); data1 = 16'($urandom);
      data2 = 16'($urandom); data3 = 16'($urandom);
      cyc(r, 4'($urandom & $urandom), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter sharing one 16-bit output bus between four requesters. Each requester presents a data word plus req/last; the arbiter grants one at a time, steers its word through a 4-way 16-bit mux tree, and emits beats on a valid/ready output. It sits between the register-file/ALU sources and any shared 16-bit sink (memory write port, output latch) in the recreated Hack datapath.

## Interface
- BURST_MAX, 4: maximum beats per grant before forced rotation (legal 1..15)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request per requester; bit i = requester i
- last  input  4  requester i marks current beat as final of its burst
- data0, data1, data2, data3  input  16 each  requester data words
- out_ready  input  1  sink accepts beat this cycle
- out_valid  output  1  beat present on out_data
- out_data  output  16  granted requester's data; 16'h0000 when out_valid=0
- grant  output  4  one-hot current grant; 4'b0000 when idle
- grant_id  output  2  encoded index of current/most recent grant

## Operation
- States: IDLE, BUSY. Reset: IDLE, grant=0, grant_id=0, ptr=0, beat_cnt=0, out_valid=0, out_data=0.
- Priority search: first set req bit in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if req!=0, register grant to the search winner, beat_cnt=0, go to BUSY. Otherwise stay.
- BUSY: out_valid = req[grant_id]; out_data = data[grant_id] when out_valid, else 0.
- Beat accepted = out_valid & out_ready; on accept beat_cnt += 1.
- Release occurs on:
  - an accepted beat with last[grant_id]=1;
  - an accepted beat with beat_cnt == BURST_MAX-1;
  - req[grant_id]=0 (abort; no beat).
- On release: ptr = grant_id+1 (mod 4), and the search re-runs in the same cycle using the new ptr against current req.
  - Winner found (the releasing requester may win only if no other req is set): new grant registered, beat_cnt=0, stay BUSY.
  - No winner: go to IDLE, grant=0, grant_id holds.
- No release: grant, grant_id, ptr unchanged; out_data must stay stable while out_valid=1 and out_ready=0 (a requester requirement; the arbiter does not latch data).
- beat_cnt width 4 bits; never exceeds BURST_MAX-1.

## Timing
- req in IDLE → grant/out_valid one cycle later (registered grant).
- Data path combinational: out_data follows data[grant_id] with zero latency.
- Back-to-back bursts: no bubble; the cycle after a releasing beat carries the next requester's first beat.
- out_valid and out_data depend combinationally on req and the data inputs; there is no path from out_ready to out_valid.
- Reset asserted mid-burst: all outputs clear immediately (asynchronously); the beat in flight is dropped. After deassertion, arbitration restarts with ptr=0.

## Structure
- Shared package bus_pkg: NUM_REQ=4, DATA_W=16, state enum {IDLE, BUSY}.
- Sub-module mux4way16: three existing 16-bit 2:1 mux instances (sel[0] on the two leaf muxes, sel[1] on the root), selected by grant_id.
- The arbiter holds the FSM, ptr, beat_cnt and the gating of out_data to zero.

## Test plan
- Single requester: req=4'b0010, data1=16'hBEEF, out_ready=1, last on 2nd beat → grant=4'b0010 one cycle after req; 2 beats of BEEF; then IDLE, grant=0, out_data=0.
- Round-robin fairness: req=4'b1111, each last=1 every beat → grant order 0,1,2,3,0 on consecutive cycles, with no idle cycle.
- Burst cap: BURST_MAX=4, req=4'b0101, last=0 → requester 0 gets exactly 4 beats, then requester 2 gets 4 beats, then requester 0 again.
- Backpressure: out_ready held 0 for 3 cycles during a grant → out_valid=1 and grant unchanged throughout; beat_cnt does not advance; the beat is accepted on the first ready cycle.
- Abort: granted requester drops req mid-burst while req[3]=1 → out_valid=0 that cycle; grant=4'b1000 on the next cycle.
- Reset mid-burst: rst_n low during beat 2 → out_valid, grant and out_data are 0 immediately; after release of reset, req=4'b1000 is granted with ptr search starting at 0.
